// File: rtl/fec_cc_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder with ping-pong block buffering.
// Optional status outputs (blk_count, overrun) are built when FEC_STATUS_EN is defined.
module fec_cc_encoder #(
  parameter int unsigned BLOCK_LEN = 96,
  parameter logic [6:0]  G1        = 7'o171,
  parameter logic [6:0]  G2        = 7'o133
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  input  logic        Valid_in,
  output logic        Ready_out,
  output logic        data_out,
  output logic        Valid_out,
  input  logic        Ready_in
`ifdef FEC_STATUS_EN
  ,
  output logic [15:0] blk_count,
  output logic        overrun
`endif
);

  localparam int unsigned   CW   = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ENC} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BLOCK_LEN-1:0] mem [2];
  logic [1:0]           full;
  logic                 wr_sel;
  logic                 rd_sel;
  logic [CW-1:0]        wr_cnt;
  logic [CW-1:0]        rd_cnt;
  logic                 phase;
  logic [5:0]           s;

  logic                 wr_en;
  logic                 wr_last;
  logic                 load_en;
  logic                 acc;
  logic                 acc_x;
  logic                 acc_y;
  logic                 last_acc;
  logic [BLOCK_LEN-1:0] rb;
  logic [5:0]           tail;
  logic [5:0]           s_shift;
  logic                 u_cur;
  logic                 u_next;

  // Bit 6 of the generator taps the current input, bit 0 the oldest state bit s[5].
  function automatic logic enc_bit(input logic [6:0] g, input logic u, input logic [5:0] st);
    logic [6:0] v;
    v = {u, st[0], st[1], st[2], st[3], st[4], st[5]};
    return ^(v & g);
  endfunction

  assign Ready_out = ~reset & ~full[wr_sel];
  assign wr_en     = Valid_in & Ready_out;
  assign wr_last   = wr_en & (wr_cnt == LAST);

  assign rb      = mem[rd_sel];
  assign tail    = {rb[BLOCK_LEN-6], rb[BLOCK_LEN-5], rb[BLOCK_LEN-4],
                    rb[BLOCK_LEN-3], rb[BLOCK_LEN-2], rb[BLOCK_LEN-1]};
  assign u_cur   = rb[rd_cnt];
  assign u_next  = rb[rd_cnt + 1'b1];
  assign s_shift = {s[4:0], u_cur};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel][wr_cnt] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= '0;
      wr_sel <= 1'b0;
      wr_cnt <= '0;
      rd_sel <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (wr_last) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      // Writer only ever targets an empty buffer, so this never collides with the set above.
      if (last_acc) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rd_sel]) state_nxt = LOAD;
      LOAD:    state_nxt = ENC;
      ENC:     if (last_acc) state_nxt = full[~rd_sel] ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    acc     = 1'b0;
    case (state)
      LOAD:    load_en = 1'b1;
      ENC:     acc = Valid_out & Ready_in;
      default: ;
    endcase
  end

  assign acc_x    = acc & ~phase;
  assign acc_y    = acc & phase;
  assign last_acc = acc_y & (rd_cnt == LAST);

  // x_0 is computed from the tail during LOAD so the first coded bit is registered without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      rd_cnt    <= '0;
      phase     <= 1'b0;
      data_out  <= 1'b0;
      Valid_out <= 1'b0;
    end else if (load_en) begin
      s         <= tail;
      rd_cnt    <= '0;
      phase     <= 1'b0;
      data_out  <= enc_bit(G1, rb[0], tail);
      Valid_out <= 1'b1;
    end else if (acc_x) begin
      data_out <= enc_bit(G2, u_cur, s);
      phase    <= 1'b1;
    end else if (acc_y) begin
      s     <= s_shift;
      phase <= 1'b0;
      if (rd_cnt == LAST) begin
        rd_cnt    <= '0;
        data_out  <= 1'b0;
        Valid_out <= 1'b0;
      end else begin
        rd_cnt   <= rd_cnt + 1'b1;
        data_out <= enc_bit(G1, u_next, s_shift);
      end
    end
  end

`ifdef FEC_STATUS_EN
  localparam int unsigned   OW   = $clog2(2 * BLOCK_LEN + 1);
  localparam logic [OW-1:0] OLIM = OW'(2 * BLOCK_LEN);

  logic [OW-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_count <= '0;
      overrun   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (last_acc) blk_count <= blk_count + 1'b1;
      // Counter saturates at 2*BLOCK_LEN; one more stalled cycle sets the sticky flag.
      if (Valid_in & ~Ready_out) begin
        if (stall_cnt == OLIM) overrun <= 1'b1;
        else                   stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Scoreboard bench for fec_cc_encoder: directed blocks push expected coded bits, a monitor pops them.
// Status-port checks are included when FEC_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_fec_cc_encoder;

  localparam logic [95:0]  VEC_IN  = 96'h558AC4A53A1724E163AC2BF9;
  localparam logic [191:0] VEC_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  logic clk;
  logic reset;
  logic data_in;
  logic Valid_in;
  logic Ready_out;
  logic data_out;
  logic Valid_out;
  logic Ready_in;
`ifdef FEC_STATUS_EN
  logic [15:0] blk_count;
  logic        overrun;
`endif

  int   tests;
  int   fails;
  int   cyc;
  int   last_acc_cyc;
  int   stall_seen;
  int   out_idx;
  bit   lat_arm;
  bit   bp_mode;
  bit   rdy_force;
  logic exp_q [$];

  fec_cc_encoder #(.BLOCK_LEN(96), .G1(7'o171), .G2(7'o133)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .Valid_in  (Valid_in),
    .Ready_out (Ready_out),
    .data_out  (data_out),
    .Valid_out (Valid_out),
    .Ready_in  (Ready_in)
`ifdef FEC_STATUS_EN
    ,
    .blk_count (blk_count),
    .overrun   (overrun)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    Ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_force)   Ready_in = 1'b0;
      else if (bp_mode) Ready_in = 1'($urandom_range(0, 1));
      else              Ready_in = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [191:0] v);
    for (int i = 191; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic send_bit(input logic b);
    bit ok;
    ok = 1'b0;
    Valid_in = 1'b1;
    data_in  = b;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      ok = Ready_out;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: Ready_out=0 for 4000 cycles, required 1");
    end else begin
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [95:0] v, input int nbits);
    for (int i = 95; i >= 96 - nbits; i--) send_bit(v[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: %0d coded bits still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks hold-stability during stalls.
  initial begin
    logic e;
    logic held;
    logic held_d;
    held    = 1'b0;
    held_d  = 1'b0;
    out_idx = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (Valid_in && !Ready_out) stall_seen++;
        if (held) begin
          tests++;
          if (!(Valid_out === 1'b1 && data_out === held_d)) begin
            fails++;
            $display("FAIL stall_hold: valid=%b data=%b, required valid=1 data=%b",
                     Valid_out, data_out, held_d);
          end
        end
        held = 1'b0;
        if (Valid_out === 1'b1) begin
          if (lat_arm) begin
            lat_arm = 1'b0;
            tests++;
            if (cyc - last_acc_cyc != 3) begin
              fails++;
              $display("FAIL first_valid_latency: %0d edges after accept, required 2",
                       cyc - last_acc_cyc - 1);
            end
          end
          if (Ready_in === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected_bit: got data_out=%b, required no valid output", data_out);
            end else begin
              e = exp_q.pop_front();
              if (data_out !== e) begin
                fails++;
                $display("FAIL coded_bit[%0d]: got %b, required %b", out_idx, data_out, e);
              end
            end
            out_idx++;
          end else begin
            held   = 1'b1;
            held_d = data_out;
          end
        end
      end
    end
  end

  initial begin
    logic [95:0]  vin;
    logic [191:0] vout;
    tests        = 0;
    fails        = 0;
    stall_seen   = 0;
    last_acc_cyc = 0;
    lat_arm      = 1'b0;
    bp_mode      = 1'b0;
    rdy_force    = 1'b1;
    vin          = VEC_IN;
    vout         = VEC_OUT;
    reset        = 1'b1;
    Valid_in     = 1'b0;
    data_in      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_out", 32'(Ready_out), 32'd0);
    check("reset_valid_out", 32'(Valid_out), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(Ready_out), 32'd1);
    @(posedge clk);
    #1;

    // Reference vector with Ready_in held high, plus first-bit latency.
    lat_arm = 1'b1;
    push_exp(vout);
    send_block(vin, 96);
    Valid_in = 1'b0;
    drain("vector");

    // Same vector under random downstream backpressure.
    bp_mode = 1'b1;
    push_exp(vout);
    send_block(vin, 96);
    Valid_in = 1'b0;
    drain("backpressure");
    bp_mode = 1'b0;
    #1;

    // Partial block discarded by a one-cycle reset, then a full block.
    send_block(vin, 40);
    Valid_in = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(vout);
    send_block(vin, 96);
    Valid_in = 1'b0;
    drain("reset_mid");

    push_exp('0);
    send_block('0, 96);
    Valid_in = 1'b0;
    drain("all_zero");

    push_exp('1);
    send_block('1, 96);
    Valid_in = 1'b0;
    drain("all_one");
`ifdef FEC_STATUS_EN
    check("blk_count_3", 32'(blk_count), 32'd3);
`endif

    // Four blocks with Valid_in never dropping.
    stall_seen = 0;
    for (int b = 0; b < 4; b++) push_exp(vout);
    for (int b = 0; b < 4; b++) send_block(vin, 96);
    Valid_in = 1'b0;
    drain("back_to_back");
    check("b2b_ready_dropped", 32'(stall_seen != 0), 32'd1);

`ifdef FEC_STATUS_EN
    check("blk_count_7", 32'(blk_count), 32'd7);
    check("overrun_idle", 32'(overrun), 32'd0);
    rdy_force = 1'b0;
    Valid_in  = 1'b1;
    data_in   = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("overrun_set", 32'(overrun), 32'd1);
    Valid_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("overrun_sticky", 32'(overrun), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rdy_force = 1'b1;
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("blk_count_cleared", 32'(blk_count), 32'd0);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("final_valid_out", 32'(Valid_out), 32'd0);
    check("final_ready_out", 32'(Ready_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fec_cc_encoder.md
Name: fec_cc_encoder

Overview:
- Rate-1/2, K=7 tail-biting convolutional encoder (IEEE 802.16 OFDM FEC), directly downstream of the PRBS randomizer.
- Accepts randomized bits serially, one per accepted beat, and buffers one full block in ping-pong storage.
- Emits 2*BLOCK_LEN coded bits serially, in X,Y order, to the interleaver.

Parameters:
- BLOCK_LEN, 96: bits per uncoded block; range 7..1024.
- G1, 7'o171: X generator; bit 6 taps u[k], bit 0 taps u[k-6].
- G2, 7'o133: Y generator, same bit mapping.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_in  input  1  randomized bit from PRBS
- Valid_in  input  1  data_in is valid
- Ready_out  output  1  encoder can accept data_in this cycle
- data_out  output  1  coded bit
- Valid_out  output  1  data_out is valid
- Ready_in  input  1  downstream accepts data_out this cycle

Behaviour:
- Reset values: Ready_out=0, Valid_out=0, data_out=0.
  - Both buffers marked empty; all counters and FSM cleared.
  - Ready_out=1 on the first cycle after reset deasserts.
- Reset mid-block discards all partial and buffered data; no coded bit from a pre-reset block appears afterwards.
- Input side:
  - A bit is written when Valid_in & Ready_out; wr_cnt increments.
  - At wr_cnt=BLOCK_LEN-1 the buffer is marked full and wr_sel toggles.
  - Ready_out = (target buffer empty).
  - Valid_in with Ready_out=0 is ignored; upstream holds data.
- Output FSM states: IDLE, LOAD, ENC.
  - IDLE -> LOAD when the rd_sel buffer is full.
  - LOAD (1 cycle): state reg s[5:0] <= {u[N-1],...,u[N-6]}, with s[0]=u[N-1]; rd_cnt=0; phase=X.
  - ENC:
    - x_k = XOR of G1 taps over {u[k], s[0..5]}; y_k likewise with G2.
    - Emit x_k, then y_k; each bit advances only on Valid_out & Ready_in.
    - After y_k is accepted, s shifts in u[k] and rd_cnt increments.
    - After y_(N-1) is accepted: buffer marked empty, rd_sel toggles; go to LOAD if the other buffer is full, else IDLE.
- Output registering: data_out/Valid_out are registered, so the first coded bit is valid 2 cycles after the block's last input bit is accepted.
- Backpressure: while Ready_in=0, data_out and Valid_out stay stable.
- Throughput: output costs 2 beats per input bit, so sustained input stalls via Ready_out; no bit is ever lost or duplicated.
- Simultaneous events:
  - Freeing a buffer in the same cycle the writer targets it: Ready_out rises the next cycle.
  - A write that fills a buffer while the reader is in IDLE: LOAD begins the next cycle.

Optional Feature:
- Macro: FEC_STATUS_EN.
- When defined, adds outputs:
  - blk_count [15:0]: increments per fully emitted block and wraps at 0xFFFF->0.
  - overrun [0:0]: sticky; set when Valid_in=1 with Ready_out=0 for more than 2*BLOCK_LEN consecutive cycles; cleared only by reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Vector check: reset, then feed 0x558AC4A53A1724E163AC2BF9 MSB-first with Ready_in=1 held; the 192 output bits equal 0x2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA MSB-first, and the first valid bit appears 2 cycles after the 96th accept.
- Back-to-back: four identical blocks with Valid_in held high; output is 4x the 192-bit vector contiguously, and Ready_out drops whenever both buffers are full.
- Backpressure: toggle Ready_in pseudo-randomly (~50%) during vector check; the accepted bit sequence is unchanged and data_out is stable during stalls.
- Reset mid-block: assert reset after 40 input bits for 1 cycle, then feed the full vector; exactly 192 valid bits out, matching expected.
- All-zero block: 96 zero bits yield 192 zero coded bits; an all-ones block yields X=1 and Y=1 per bit (both generators have odd tap count 5).
- FEC_STATUS_EN: after 3 blocks, blk_count=3; hold Valid_in=1 with Ready_in=0 for 400 cycles and overrun=1 persists until reset.
